// File: rtl/knn_list_ctrl.sv
// Query sequencer for a K-entry KNN insertion list: clears the list, streams
// N candidates into it, then reads the K nearest entries out over valid/ready.
module knn_list_ctrl #(
  parameter int DATA_W = 32,
  parameter int LABEL  = 8,
  parameter int K      = 4,
  parameter int K_W    = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        n_points,
  input  logic [DATA_W-1:0]       cand_dist,
  input  logic [LABEL-1:0]        cand_label,
  input  logic                    cand_valid,
  output logic                    cand_ready,
  output logic                    list_clr,
  output logic                    list_valid,
  output logic [DATA_W-1:0]       list_dist,
  output logic [LABEL-1:0]        list_label,
  output logic [K_W-1:0]          list_rd_idx,
  input  logic [DATA_W+LABEL-1:0] list_rd_data,
  output logic [DATA_W-1:0]       nb_dist,
  output logic [LABEL-1:0]        nb_label,
  output logic                    nb_valid,
  input  logic                    nb_ready,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // a producer holds valid and data stable until that edge.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FILL   = 3'd2,
    S_SETTLE = 3'd3,
    S_READ   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_lim;
  logic [K_W-1:0]   idx;
  logic             accept, last_cand, last_nb, nb_take;

  assign accept      = (state == S_FILL) && cand_valid;
  assign last_cand   = (cnt + CNT_W'(1)) == cnt_lim;
  assign last_nb     = idx == K_W'(K - 1);
  assign nb_take     = nb_valid && nb_ready;
  assign list_rd_idx = idx;
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cand_ready = 1'b0;
    list_clr   = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE:   if (start) state_nxt = S_CLEAR;
      S_CLEAR: begin
        list_clr  = 1'b1;
        state_nxt = (cnt_lim != '0) ? S_FILL : S_READ;
      end
      S_FILL: begin
        cand_ready = 1'b1;
        if (accept && last_cand) state_nxt = S_SETTLE;
      end
      S_SETTLE: state_nxt = S_READ;
      S_READ:   if (nb_take && last_nb) state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      cnt_lim    <= '0;
      idx        <= '0;
      list_valid <= 1'b0;
      list_dist  <= '0;
      list_label <= '0;
      nb_dist    <= '0;
      nb_label   <= '0;
      nb_valid   <= 1'b0;
    end else begin
      list_valid <= accept;
      if (accept) begin
        list_dist  <= cand_dist;
        list_label <= cand_label;
        cnt        <= cnt + CNT_W'(1);
      end
      if (state == S_IDLE && start) begin
        cnt_lim <= n_points;
        cnt     <= '0;
      end
      if (state == S_CLEAR || state == S_SETTLE) idx <= '0;
      // Each entry: one cycle with nb_valid low while the new entry loads.
      if (state == S_READ) begin
        if (!nb_valid) begin
          nb_dist  <= list_rd_data[DATA_W+LABEL-1:LABEL];
          nb_label <= list_rd_data[LABEL-1:0];
          nb_valid <= 1'b1;
        end else if (nb_ready) begin
          nb_valid <= 1'b0;
          idx      <= idx + K_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_knn_list_ctrl.sv
// Bench for knn_list_ctrl: behavioural K-entry sorted insertion list, table of
// queries with hand-derived neighbour results, and a reset-abort sequence.
module tb_knn_list_ctrl;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int K  = 4;
  localparam int KW = 2;
  localparam int CW = 16;
  localparam logic [DW-1:0] ONES = '1;

  logic          clk, rst, start;
  logic [CW-1:0] n_points;
  logic [DW-1:0] cand_dist;
  logic [LW-1:0] cand_label;
  logic          cand_valid, cand_ready, list_clr, list_valid;
  logic [DW-1:0] list_dist;
  logic [LW-1:0] list_label;
  logic [KW-1:0] list_rd_idx;
  logic [DW+LW-1:0] list_rd_data;
  logic [DW-1:0] nb_dist;
  logic [LW-1:0] nb_label;
  logic          nb_valid, nb_ready, busy, done;
  logic [2:0]    dbg_state;

  knn_list_ctrl #(.DATA_W(DW), .LABEL(LW), .K(K), .K_W(KW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .n_points(n_points),
    .cand_dist(cand_dist), .cand_label(cand_label), .cand_valid(cand_valid),
    .cand_ready(cand_ready), .list_clr(list_clr), .list_valid(list_valid),
    .list_dist(list_dist), .list_label(list_label), .list_rd_idx(list_rd_idx),
    .list_rd_data(list_rd_data), .nb_dist(nb_dist), .nb_label(nb_label),
    .nb_valid(nb_valid), .nb_ready(nb_ready), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural insertion list ----------------
  logic [DW-1:0] m_d[K];
  logic [LW-1:0] m_l[K];
  assign list_rd_data = {m_d[list_rd_idx], m_l[list_rd_idx]};

  always @(posedge clk) begin
    logic [DW-1:0] td[K];
    logic [LW-1:0] tl[K];
    int p;
    for (int j = 0; j < K; j++) begin td[j] = m_d[j]; tl[j] = m_l[j]; end
    if (list_clr) begin
      for (int j = 0; j < K; j++) begin td[j] = ONES; tl[j] = '0; end
    end else if (list_valid) begin
      p = K;
      for (int j = K - 1; j >= 0; j--) if (list_dist < td[j]) p = j;
      if (p < K) begin
        for (int j = K - 1; j > p; j--) begin td[j] = td[j-1]; tl[j] = tl[j-1]; end
        td[p] = list_dist;
        tl[p] = list_label;
      end
    end
    for (int j = 0; j < K; j++) begin m_d[j] <= td[j]; m_l[j] <= tl[j]; end
  end

  // ---------------- insert-strobe monitor ----------------
  int ins_total = 0, ins_runs = 0, clr_overlap = 0;
  logic prev_lv = 1'b0;
  always @(negedge clk) begin
    if (list_valid) begin
      ins_total++;
      if (!prev_lv) ins_runs++;
    end
    if (list_clr && list_valid) clr_overlap++;
    prev_lv = list_valid;
  end

  // ---------------- scoreboard ----------------
  int total = 0, bad = 0;
  logic [DW+LW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    int                  n;
    logic [0:5][DW-1:0]  d;
    logic [0:5][LW-1:0]  l;
    logic [0:3][DW-1:0]  ed;
    logic [0:3][LW-1:0]  el;
    bit                  gaps;
    bit                  stall;
  } vec_t;

  vec_t vecs[4];

  // ---------------- driver tasks ----------------
  task automatic run_query(input vec_t v);
    int i, guard, hs, stall_n, ins0, runs0, ovl0;
    logic [DW-1:0] held_d;
    logic [LW-1:0] held_l;
    logic [KW-1:0] held_i;
    logic [DW+LW-1:0] e;
    for (int j = 0; j < K; j++) exp_q.push_back({v.ed[j], v.el[j]});
    ins0 = ins_total; runs0 = ins_runs; ovl0 = clr_overlap;
    nb_ready = 1'b0;
    @(negedge clk); start = 1'b1; n_points = CW'(v.n);
    @(negedge clk); start = 1'b0;
    chk("clear_strobe", list_clr, 1'b1);
    i = 0; guard = 0;
    while (i < v.n && guard < 500) begin
      @(negedge clk); guard++;
      if (v.gaps && $urandom_range(0, 2) == 0) begin
        cand_valid = 1'b0;
      end else begin
        cand_valid = 1'b1; cand_dist = v.d[i]; cand_label = v.l[i];
        if (cand_ready) i++;
      end
    end
    if (i < v.n) chk("fill_timeout", 64'(i), 64'(v.n));
    // keep offering data and pulse start: nothing more may be taken
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cand_valid = 1'b1; cand_dist = 32'd0; cand_label = 8'hEE;
      start = (k == 0); n_points = 16'd99;
      chk("hold_cand_ready", cand_ready, 1'b0);
      chk("hold_busy", busy, 1'b1);
    end
    hs = 0; guard = 0; stall_n = 0;
    held_d = '0; held_l = '0; held_i = '0;
    while (hs < K && guard < 300) begin
      @(negedge clk); guard++;
      cand_valid = 1'b0; start = 1'b0;
      if (v.stall && hs == 1 && nb_valid && stall_n < 5) begin
        if (stall_n == 0) begin
          held_d = nb_dist; held_l = nb_label; held_i = list_rd_idx;
        end else begin
          chk("stall_valid", nb_valid, 1'b1);
          chk("stall_dist", nb_dist, held_d);
          chk("stall_label", nb_label, held_l);
          chk("stall_idx", list_rd_idx, held_i);
        end
        nb_ready = 1'b0;
        stall_n++;
      end else begin
        nb_ready = v.gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (nb_valid && nb_ready) begin
          if (exp_q.size() == 0) chk("exp_q_underflow", 64'(1), 64'(0));
          else begin
            e = exp_q.pop_front();
            chk("nb_dist", nb_dist, e[DW+LW-1:LW]);
            chk("nb_label", nb_label, e[LW-1:0]);
          end
          hs++;
        end
      end
    end
    if (hs < K) chk("read_timeout", 64'(hs), 64'(K));
    @(negedge clk); nb_ready = 1'b0;
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b1);
    chk("done_nb_valid", nb_valid, 1'b0);
    @(negedge clk);
    chk("after_done", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_state", dbg_state, 3'd0);
    chk("insert_count", 64'(ins_total - ins0), 64'(v.n));
    if (!v.gaps) chk("insert_runs", 64'(ins_runs - runs0), 64'(v.n > 0 ? 1 : 0));
    chk("clr_overlap", 64'(clr_overlap - ovl0), 64'(0));
    chk("exp_q_empty", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{n: 6,
                d: {32'd9, 32'd3, 32'd7, 32'd1, 32'd8, 32'd2},
                l: {8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15},
                ed: {32'd1, 32'd2, 32'd3, 32'd7},
                el: {8'd13, 8'd15, 8'd11, 8'd12},
                gaps: 1'b0, stall: 1'b1};
    vecs[1] = '{n: 2,
                d: {32'd5, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0},
                l: {8'd20, 8'd21, 8'd0, 8'd0, 8'd0, 8'd0},
                ed: {32'd4, 32'd5, ONES, ONES},
                el: {8'd21, 8'd20, 8'd0, 8'd0},
                gaps: 1'b0, stall: 1'b0};
    vecs[2] = '{n: 0,
                d: '0, l: '0,
                ed: {ONES, ONES, ONES, ONES},
                el: {8'd0, 8'd0, 8'd0, 8'd0},
                gaps: 1'b0, stall: 1'b0};
    vecs[3] = '{n: 5,
                d: {32'd6, 32'd5, 32'd2, 32'd9, 32'd1, 32'd0},
                l: {8'd30, 8'd31, 8'd32, 8'd33, 8'd34, 8'd0},
                ed: {32'd1, 32'd2, 32'd5, 32'd6},
                el: {8'd34, 8'd32, 8'd31, 8'd30},
                gaps: 1'b1, stall: 1'b0};

    rst = 1'b0; start = 1'b0; n_points = '0;
    cand_dist = '0; cand_label = '0; cand_valid = 1'b0; nb_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cand_ready", cand_ready, 1'b0);
    chk("rst_list_clr", list_clr, 1'b0);
    chk("rst_list_valid", list_valid, 1'b0);
    chk("rst_nb_valid", nb_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_idx", list_rd_idx, 2'd0);
    chk("rst_state", dbg_state, 3'd0);
    rst = 1'b1;

    for (int q = 0; q < 4; q++) run_query(vecs[q]);

    // reset mid-FILL after three candidates have been accepted
    begin
      int i, guard;
      @(negedge clk); start = 1'b1; n_points = 16'd6;
      @(negedge clk); start = 1'b0;
      i = 0; guard = 0;
      while (i < 3 && guard < 50) begin
        @(negedge clk); guard++;
        cand_valid = 1'b1; cand_dist = 32'(i + 40); cand_label = 8'(i);
        if (cand_ready) i++;
      end
      @(negedge clk); cand_valid = 1'b0;
      chk("abort_in_fill", dbg_state, 3'd2);
      rst = 1'b0;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_cand_ready", cand_ready, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_state", dbg_state, 3'd0);
      @(negedge clk);
      chk("abort_list_valid", list_valid, 1'b0);
      chk("abort_done_later", done, 1'b0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort_idle_busy", busy, 1'b0);
      chk("abort_idle_done", done, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
